// File: rtl/ps2_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ps2_tx_arbiter
//
// Shares a single PS/2 byte transmitter between NREQ requesters (for example
// a switch bank, a loopback checker and a host echo path). Requesters are
// picked in round-robin order. The winning byte is latched and handed to the
// transmitter with a one-cycle start pulse. The arbiter then waits for the
// transmitter's done pulse, or gives up after TIMEOUT_CYCLES. Every frame is
// followed by an idle gap, so the PS/2 line gets its required inter-frame
// quiet time.
//
// Ports
//   clk       system clock (16 MHz)
//   reset     asynchronous, active-high reset
//   req       level request per requester; held until its own ack/err
//   req_data  byte for requester i at [8i+7:8i]; stable while req[i] is high
//   ack       1-cycle pulse: the requester's byte was sent
//   err       1-cycle pulse: the requester's transfer timed out
//   grant     one-hot owner; high from START through the WAIT_DONE exit cycle
//   tx_start  1-cycle start pulse to the transmitter
//   tx_data   byte to the transmitter; stable from one START until the next
//   tx_busy   transmitter busy (level)
//   tx_done   transmitter frame complete (1-cycle pulse)
//   busy      high whenever the arbiter is not idle
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module ps2_tx_arbiter #(
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CYCLES = 32000,
   parameter int GAP_CYCLES     = 800,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     err,
   output logic [NREQ-1:0]     grant,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_busy,
   input  logic                tx_done,
   output logic                busy
);

   // Index width for requester numbers. IDX_W has one extra bit so the
   // round-robin candidate can be formed before the modulo wrap.
   localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IDX_W = SEL_W + 1;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam longint           CNT_MAX  = (longint'(1) << CNT_W) - 1;

   // ------------------------------------------------------------------
   // Configuration checks. These are evaluated during elaboration.
   // ------------------------------------------------------------------
   generate
      if (NREQ < 2 || NREQ > 4) begin : g_cfg_nreq
         $error("ps2_tx_arbiter: NREQ=%0d outside supported range 2..4", NREQ);
      end
      if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_cfg_zero
         $error("ps2_tx_arbiter: TIMEOUT_CYCLES and GAP_CYCLES must be >= 1");
      end
      if (longint'(TIMEOUT_CYCLES) > CNT_MAX || longint'(GAP_CYCLES) > CNT_MAX) begin : g_cfg_cnt
         $error("ps2_tx_arbiter: CNT_W=%0d too small for TIMEOUT_CYCLES/GAP_CYCLES", CNT_W);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t               state_reg;
   logic [SEL_W-1:0]     sel_reg;
   logic [SEL_W-1:0]     last_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 gap_entry_reg;
   logic [NREQ-1:0]      grant_reg;
   logic [NREQ-1:0]      ack_reg;
   logic [NREQ-1:0]      err_reg;
   logic                 tx_start_reg;
   logic [7:0]           tx_data_reg;
   logic                 busy_reg;

   // Unpack the flat byte bus into one entry per requester.
   logic [7:0]           data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign data_arr[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Round-robin pick. The search starts at last+1 and walks forward,
   // wrapping modulo NREQ, so the previous owner is considered last.
   // ------------------------------------------------------------------
   logic [SEL_W-1:0]     pick;
   logic                 pick_found;
   logic [IDX_W-1:0]     cand_idx;
   logic [NREQ-1:0]      pick_onehot;

   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      cand_idx   = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand_idx = {1'b0, last_reg} + IDX_W'(off);
         if (cand_idx >= IDX_W'(NREQ)) begin
            cand_idx = cand_idx - IDX_W'(NREQ);
         end
         if (!pick_found && req[cand_idx[SEL_W-1:0]]) begin
            pick       = cand_idx[SEL_W-1:0];
            pick_found = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick == SEL_W'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Controller. All outputs are registered here.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         sel_reg       <= '0;
         last_reg      <= SEL_W'(NREQ - 1);
         cnt_reg       <= '0;
         gap_entry_reg <= 1'b0;
         grant_reg     <= '0;
         ack_reg       <= '0;
         err_reg       <= '0;
         tx_start_reg  <= 1'b0;
         tx_data_reg   <= '0;
         busy_reg      <= 1'b0;
      end else begin
         // Pulse outputs default low. Each is raised for exactly one cycle
         // by the state that owns it.
         tx_start_reg <= 1'b0;
         ack_reg      <= '0;
         err_reg      <= '0;

         case (state_reg)
            S_IDLE: begin
               // A busy transmitter blocks arbitration entirely. The byte
               // is latched here, so later req_data changes are ignored.
               if (pick_found && !tx_busy) begin
                  sel_reg     <= pick;
                  tx_data_reg <= data_arr[pick];
                  grant_reg   <= pick_onehot;
                  busy_reg    <= 1'b1;
                  state_reg   <= S_START;
               end
            end

            S_START: begin
               tx_start_reg <= 1'b1;
               cnt_reg      <= '0;
               state_reg    <= S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
               // When done and the timeout coincide, done takes priority.
               // grant_reg is the one-hot of sel here, so it drives
               // ack/err directly.
               if (tx_done || cnt_reg == TO_LAST) begin
                  if (tx_done) begin
                     ack_reg <= grant_reg;
                  end else begin
                     err_reg <= grant_reg;
                  end
                  grant_reg     <= '0;
                  cnt_reg       <= '0;
                  gap_entry_reg <= 1'b1;
                  last_reg      <= sel_reg;
                  state_reg     <= S_GAP;
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            S_GAP: begin
               // The first GAP cycle (the ack/err cycle) only clears the
               // counter. GAP_CYCLES counted cycles follow it, so the line
               // stays quiet for GAP_CYCLES+1 cycles after each frame.
               if (gap_entry_reg) begin
                  gap_entry_reg <= 1'b0;
                  cnt_reg       <= '0;
               end else if (cnt_reg == GAP_LAST) begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            default: begin
               grant_reg <= '0;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign ack      = ack_reg;
   assign err      = err_reg;
   assign grant    = grant_reg;
   assign tx_start = tx_start_reg;
   assign tx_data  = tx_data_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_ps2_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_tx_arbiter. The bench holds a timeline model of the
// arbiter. For each frame it records the edge at which the owner was picked
// and the edge at which the frame ended. Expected outputs for every cycle
// are then derived from those timestamps with simple arithmetic. Directed
// scenarios add literal timing and data expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_ps2_tx_arbiter;

   localparam int NREQ = 2;
   localparam int TO   = 200;
   localparam int GP   = 20;
   localparam int CW   = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [8*NREQ-1:0]   req_data;
   logic [NREQ-1:0]     ack;
   logic [NREQ-1:0]     err;
   logic [NREQ-1:0]     grant;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;
   logic                tx_done;
   logic                busy;

   ps2_tx_arbiter #(
      .NREQ           (NREQ),
      .TIMEOUT_CYCLES (TO),
      .GAP_CYCLES     (GP),
      .CNT_W          (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .err      (err),
      .grant    (grant),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_starts = 0;
   int n_acks   = 0;
   int n_errs   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Timeline model. m_e counts clock edges since reset release. A frame
   // is described by m_sel (the pick edge), m_end (the end edge, or -1
   // while it is open) and its outcome.
   // ------------------------------------------------------------------
   int              m_e, m_sel, m_end, m_owner, m_last, m_cand;
   bit              m_have, m_is_ack, m_found;
   logic [7:0]      m_data;
   logic [NREQ-1:0] m_req_sh;
   logic [8*NREQ-1:0] m_data_sh;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_e = 0; m_have = 0; m_sel = 0; m_end = -1; m_owner = 0;
         m_last = NREQ - 1; m_is_ack = 0; m_data = 8'h00;
      end else begin
         m_e++;
         if (m_have && m_end < 0) begin
            // Done is honoured from the edge after tx_start onward. The
            // timeout edge lands TO edges after the tx_start edge.
            if (m_e >= m_sel + 2) begin
               if (tx_done) begin
                  m_end = m_e; m_is_ack = 1; m_last = m_owner;
               end else if (m_e == m_sel + TO + 1) begin
                  m_end = m_e; m_is_ack = 0; m_last = m_owner;
               end
            end
         end else if (!m_have || m_e >= m_end + GP + 2) begin
            if ((|req) && !tx_busy) begin
               m_found = 0;
               for (int off = 1; off <= NREQ; off++) begin
                  m_cand   = (m_last + off) % NREQ;
                  m_req_sh = req >> m_cand;
                  if (!m_found && m_req_sh[0]) begin
                     m_found   = 1;
                     m_owner   = m_cand;
                     m_data_sh = req_data >> (8 * m_cand);
                     m_data    = m_data_sh[7:0];
                  end
               end
               m_have = 1; m_sel = m_e; m_end = -1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Compare process. It checks every output on every falling edge.
   // ------------------------------------------------------------------
   logic [NREQ-1:0] oh, exp_grant, exp_ack, exp_err;
   logic            exp_busy, exp_start;

   always @(negedge clk) begin
      if (reset) begin
         chk("reset grant", 32'(grant), 0);
         chk("reset busy", 32'(busy), 0);
         chk("reset tx_start", 32'(tx_start), 0);
         chk("reset tx_data", 32'(tx_data), 0);
         chk("reset ack", 32'(ack), 0);
         chk("reset err", 32'(err), 0);
      end else begin
         oh        = NREQ'(1) << m_owner;
         exp_busy  = m_have && (m_end < 0 || m_e <= m_end + GP);
         exp_grant = (m_have && (m_end < 0 || m_e < m_end)) ? oh : '0;
         exp_start = m_have && (m_e == m_sel + 1);
         exp_ack   = (m_have && m_end == m_e && m_is_ack)  ? oh : '0;
         exp_err   = (m_have && m_end == m_e && !m_is_ack) ? oh : '0;
         chk("model busy", 32'(busy), 32'(exp_busy));
         chk("model grant", 32'(grant), 32'(exp_grant));
         chk("model tx_start", 32'(tx_start), 32'(exp_start));
         chk("model tx_data", 32'(tx_data), 32'(m_data));
         chk("model ack", 32'(ack), 32'(exp_ack));
         chk("model err", 32'(err), 32'(exp_err));
      end
      if (tx_start) n_starts++;
      if (|ack) n_acks++;
      if (|err) n_errs++;
      if ((|ack) || (|err))
         $display("[TB] txn @%0d: ack=%b err=%b data=%h", cyc, ack, err, tx_data);
   end

   // ------------------------------------------------------------------
   // Helpers. Every wait is bounded.
   // ------------------------------------------------------------------
   task automatic wait_start(output int s, output logic [7:0] d, output logic [NREQ-1:0] g);
      s = -1; d = 8'h00; g = '0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_start) begin
            s = cyc; d = tx_data; g = grant;
            return;
         end
      end
      chk("wait tx_start bound", 0, 1);
   endtask

   task automatic wait_result(output int c, output logic [NREQ-1:0] a, output logic [NREQ-1:0] e);
      c = -1; a = '0; e = '0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if ((|ack) || (|err)) begin
            c = cyc; a = ack; e = err;
            return;
         end
      end
      chk("wait ack/err bound", 0, 1);
   endtask

   task automatic wait_idle(output int c);
      c = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!busy) begin
            c = cyc;
            return;
         end
      end
      chk("wait idle bound", 0, 1);
   endtask

   // Called at the falling edge of cycle S: tx_done goes high in cycle S+k.
   task automatic pulse_done(input int k);
      repeat (k) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------
   initial begin
      int s, c, f, prev_ack, na, ne;
      logic [7:0] d;
      logic [NREQ-1:0] g, a, e;
      logic [7:0] exp_order [4];
      int exp_grant_k [4];

      reset = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("init busy", 32'(busy), 0);
      chk("init grant", 32'(grant), 0);
      chk("init tx_data", 32'(tx_data), 0);
      chk("init tx_start", 32'(tx_start), 0);
      @(negedge clk) reset = 1'b0;

      // Contention: both requesters are held and alternate 0,1,0,1.
      exp_order   = '{8'h11, 8'h22, 8'h11, 8'h22};
      exp_grant_k = '{1, 2, 1, 2};
      prev_ack = 0;
      @(posedge clk); #1 req_data = {8'h22, 8'h11}; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_start(s, d, g);
         chk("contention data", 32'(d), 32'(exp_order[k]));
         chk("contention grant", 32'(g), 32'(exp_grant_k[k]));
         if (k > 0) chk("contention gap", 32'((s - prev_ack) >= GP), 1);
         pulse_done(5);
         wait_result(c, a, e);
         chk("contention ack", 32'(a), 32'(exp_grant_k[k]));
         prev_ack = c;
      end
      @(posedge clk); #1 req = '0;
      wait_idle(f);

      // Single requester with tx_done 50 cycles after tx_start.
      @(posedge clk); #1 req_data = {8'h00, 8'hA5}; req = 2'b01;
      na = n_acks;
      wait_start(s, d, g);
      chk("single data", 32'(d), 'hA5);
      chk("single grant", 32'(g), 1);
      pulse_done(50);
      wait_result(c, a, e);
      chk("single ack", 32'(a), 1);
      chk("single ack latency", 32'(c - s), 51);
      @(posedge clk); #1 req = '0;
      wait_idle(f);
      chk("single busy low after ack", 32'(f - c), 32'(GP + 1));
      chk("single ack count", 32'(n_acks - na), 1);

      // Timeout on requester 1, then requester 0 is still served.
      @(posedge clk); #1 req_data = {8'h5A, 8'h00}; req = 2'b10;
      wait_start(s, d, g);
      chk("timeout data", 32'(d), 'h5A);
      chk("timeout grant", 32'(g), 2);
      wait_result(c, a, e);
      chk("timeout err", 32'(e), 2);
      chk("timeout no ack", 32'(a), 0);
      chk("timeout latency", 32'(c - s), 32'(TO));
      @(posedge clk); #1 req = 2'b01; req_data = {8'h00, 8'h3C};
      wait_start(s, d, g);
      chk("after timeout data", 32'(d), 'h3C);
      pulse_done(3);
      wait_result(c, a, e);
      chk("after timeout ack", 32'(a), 1);
      @(posedge clk); #1 req = '0;
      wait_idle(f);

      // A busy transmitter blocks arbitration.
      @(posedge clk); #1 tx_busy = 1'b1; req = 2'b01; req_data = {8'h00, 8'h77};
      na = n_starts;
      repeat (100) @(posedge clk);
      #1 tx_busy = 1'b0;
      f = cyc;
      chk("busy hold no start", 32'(n_starts - na), 0);
      wait_start(s, d, g);
      chk("busy release latency", 32'(s - f), 2);
      chk("busy release data", 32'(d), 'h77);
      pulse_done(4);
      wait_result(c, a, e);
      chk("busy release ack", 32'(a), 1);
      @(posedge clk); #1 req = '0;
      wait_idle(f);

      // tx_done and the timeout land on the same edge: done wins.
      @(posedge clk); #1 req = 2'b01; req_data = {8'h00, 8'hC3};
      ne = n_errs;
      wait_start(s, d, g);
      pulse_done(TO - 1);
      wait_result(c, a, e);
      chk("coincide ack", 32'(a), 1);
      chk("coincide err", 32'(e), 0);
      chk("coincide latency", 32'(c - s), 32'(TO));
      @(posedge clk); #1 req = '0;
      wait_idle(f);
      chk("coincide err count", 32'(n_errs - ne), 0);

      // Reset in the middle of WAIT_DONE.
      @(posedge clk); #1 req = 2'b01; req_data = {8'h00, 8'h99};
      wait_start(s, d, g);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      na = n_acks; ne = n_errs;
      #1;
      chk("mid reset grant", 32'(grant), 0);
      chk("mid reset busy", 32'(busy), 0);
      chk("mid reset tx_start", 32'(tx_start), 0);
      chk("mid reset tx_data", 32'(tx_data), 0);
      chk("mid reset ack", 32'(ack), 0);
      chk("mid reset err", 32'(err), 0);
      req = 2'b11; req_data = {8'hBB, 8'hAA};
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      wait_start(s, d, g);
      chk("post reset grant", 32'(g), 1);
      chk("post reset data", 32'(d), 'hAA);
      chk("post reset no ack/err", 32'((n_acks - na) + (n_errs - ne)), 0);
      pulse_done(2);
      wait_result(c, a, e);
      chk("post reset ack", 32'(a), 1);
      @(posedge clk); #1 req = '0;
      wait_idle(f);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
